// File: rtl/fetch_unit.sv
// ============================================================================
//  fetch_unit
//  Instruction fetch: issues word reads, buffers {pc, inst} in a 2-entry FIFO
//  and hands words to decode over valid/ready.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] inst_out,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;

  logic        head_vld_q, head_vld_d;
  logic [15:0] head_pc_q, head_pc_d;
  logic [15:0] head_inst_q, head_inst_d;
  logic        tail_vld_q, tail_vld_d;
  logic [15:0] tail_pc_q, tail_pc_d;
  logic [15:0] tail_inst_q, tail_inst_d;

  logic        pop;
  logic        push;
  logic        rd_en;
  logic [2:0]  level;
  logic [2:0]  limit;

  assign pop   = head_vld_q & inst_ready;
  // Returning data is only kept while running; SQUASH drops the stale return.
  assign push  = inflight_q & (state_q == RUN) & ~redirect;
  assign level = {2'b00, head_vld_q} + {2'b00, tail_vld_q} + {2'b00, inflight_q};
  assign limit = 3'd2 + {2'b00, pop};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    head_vld_d    = head_vld_q;
    head_pc_d     = head_pc_q;
    head_inst_d   = head_inst_q;
    tail_vld_d    = tail_vld_q;
    tail_pc_d     = tail_pc_q;
    tail_inst_d   = tail_inst_q;
    rd_en         = 1'b0;

    case (state_q)
      START: begin
        state_d = RUN;
      end
      RUN: begin
        rd_en = (level < limit) & ~redirect;
      end
      SQUASH: begin
        rd_en   = ~redirect;
        state_d = RUN;
      end
      default: begin
        state_d = START;
      end
    endcase

    if (rd_en) begin
      fetch_pc_d    = fetch_pc_q + 16'd1;
      inflight_pc_d = fetch_pc_q;
    end
    inflight_d = rd_en;

    // Head register feeds the outputs directly; tail only holds the overflow.
    if (push && pop) begin
      if (tail_vld_q) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
        tail_pc_d   = inflight_pc_q;
        tail_inst_d = mem_rdata;
      end else begin
        head_pc_d   = inflight_pc_q;
        head_inst_d = mem_rdata;
      end
    end else if (pop) begin
      if (tail_vld_q) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
        tail_vld_d  = 1'b0;
      end else begin
        head_vld_d  = 1'b0;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_pc_d   = inflight_pc_q;
        head_inst_d = mem_rdata;
      end else begin
        tail_vld_d  = 1'b1;
        tail_pc_d   = inflight_pc_q;
        tail_inst_d = mem_rdata;
      end
    end

    if (redirect) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
      fetch_pc_d = redirect_pc;
      state_d    = inflight_q ? SQUASH : RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= START;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      head_vld_q    <= 1'b0;
      head_pc_q     <= 16'h0000;
      head_inst_q   <= 16'h0000;
      tail_vld_q    <= 1'b0;
      tail_pc_q     <= 16'h0000;
      tail_inst_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_vld_q    <= head_vld_d;
      head_pc_q     <= head_pc_d;
      head_inst_q   <= head_inst_d;
      tail_vld_q    <= tail_vld_d;
      tail_pc_q     <= tail_pc_d;
      tail_inst_q   <= tail_inst_d;
    end
  end

  assign mem_rd_en  = rd_en;
  assign mem_addr   = fetch_pc_q;
  assign inst_out   = head_inst_q;
  assign inst_pc    = head_pc_q;
  assign inst_valid = head_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  tb_fetch_unit
//  Scoreboard bench for fetch_unit with a one-cycle-latency memory model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_en, mem_rd_en2;
  logic [15:0] mem_addr, mem_addr2;
  logic [15:0] mem_rdata, mem_rdata2;
  logic [15:0] inst_out, inst_out2;
  logic [15:0] inst_pc, inst_pc2;
  logic        inst_valid, inst_valid2;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n2     = 0;
  logic [15:0] held_out, held_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .mem_rd_en   (mem_rd_en2),
    .mem_addr    (mem_addr2),
    .mem_rdata   (mem_rdata2),
    .inst_out    (inst_out2),
    .inst_pc     (inst_pc2),
    .inst_valid  (inst_valid2),
    .inst_ready  (1'b1),
    .redirect    (1'b0),
    .redirect_pc (16'h0000)
  );

  // Memory: word(a) = a ^ A500, data valid the cycle after the sampled read.
  always @(posedge clk) begin
    mem_rdata  <= mem_rd_en  ? (mem_addr  ^ 16'hA500) : 16'hDEAD;
    mem_rdata2 <= mem_rd_en2 ? (mem_addr2 ^ 16'hA500) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic load_stream(input logic [15:0] start);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc   = start + 16'(i);
      e.inst = e.pc ^ 16'hA500;
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic [15:0] p2;
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", {31'd0, inst_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", inst_pc, e.pc);
        check("xfer_inst", inst_out, e.inst);
      end
    end
    if (inst_valid2 && n2 < 4) begin
      p2 = 16'hFFFE + 16'(n2);
      check("wrap_pc", inst_pc2, p2);
      check("wrap_inst", inst_out2, p2 ^ 16'hA500);
      n2++;
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      wait_neg();
      wait_pos();
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      wait_neg();
      seen = inst_valid;
      wait_pos();
    end
    check("valid_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'h0000);
    check({tag, "_valid"}, inst_valid, 32'd0);
    check({tag, "_inst"}, inst_out, 32'h0000);
    check({tag, "_pc"}, inst_pc, 32'h0000);
    check({tag, "_addr2"}, mem_addr2, 32'hFFFE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    wait_neg();
    check_reset_outputs("rst");
    wait_pos();

    // Reset release: cycle 0 is START, read in cycle 1, valid in cycle 3.
    reset = 1'b1;
    n2    = 0;
    load_stream(16'h0000);
    wait_neg(); check("start_no_read", mem_rd_en, 32'd0); wait_pos();
    wait_neg(); check("first_rd_en", mem_rd_en, 32'd1);
    check("first_rd_addr", mem_addr, 32'h0000); wait_pos();
    wait_neg(); check("lat_c2_valid", inst_valid, 32'd0); wait_pos();
    wait_neg(); check("lat_c3_valid", inst_valid, 32'd1); wait_pos();
    for (int i = 0; i < 8; i++) begin
      wait_neg(); check("stream_valid", inst_valid, 32'd1); wait_pos();
    end

    // Back-pressure: outputs hold, reads stop once the FIFO fills.
    inst_ready = 1'b0;
    wait_neg();
    held_out = inst_out;
    held_pc  = inst_pc;
    wait_pos();
    for (int i = 1; i < 5; i++) begin
      wait_neg();
      check("stall_out", inst_out, held_out);
      check("stall_pc", inst_pc, held_pc);
      check("stall_rd_en", mem_rd_en, 32'd0);
      check("stall_valid", inst_valid, 32'd1);
      wait_pos();
    end
    inst_ready = 1'b1;
    run(10);

    // Redirect with a read in flight and a completing handshake.
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    wait_neg();
    check("redir_rd_en", mem_rd_en, 32'd0);
    check("redir_hs_valid", inst_valid, 32'd1);
    wait_pos();
    redirect = 1'b0;
    load_stream(16'h0040);
    wait_neg(); check("post_redir_valid1", inst_valid, 32'd0); wait_pos();
    wait_neg(); check("post_redir_valid2", inst_valid, 32'd0); wait_pos();
    wait_valid(10);
    run(6);

    // Redirect with no handshake on the redirect edge.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    wait_neg(); wait_pos();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    load_stream(16'h0100);
    wait_valid(10);
    run(6);

    // Second redirect during SQUASH: 0x0200 must never surface.
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    wait_neg(); wait_pos();
    redirect_pc = 16'h0300;
    wait_neg();
    check("resquash_rd_en", mem_rd_en, 32'd0);
    wait_pos();
    redirect = 1'b0;
    load_stream(16'h0300);
    wait_valid(10);
    run(6);

    // Asynchronous reset pulse with a full FIFO.
    inst_ready = 1'b0;
    run(3);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wait_neg(); wait_pos();
    reset      = 1'b1;
    inst_ready = 1'b1;
    n2         = 0;
    load_stream(16'h0000);
    wait_valid(10);
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 16'h0000, first word address fetched after reset.
REQ-002 The block SHALL have these ports, one clock and one reset (clk; reset is asynchronous and active-low):
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd_en  output  1  instruction-memory read strobe.
- mem_addr  output  16  word address of the read.
- mem_rdata  input  16  read data, valid in the cycle after the edge that sampled mem_rd_en=1.
- inst_out  output  16  instruction word presented to the decoder.
- inst_pc  output  16  address inst_out was fetched from.
- inst_valid  output  1  inst_out/inst_pc valid.
- inst_ready  input  1  decoder accepts; transfer occurs on an edge with inst_valid=1 and inst_ready=1.
- redirect  input  1  branch/jump taken; discard the fetch stream.
- redirect_pc  input  16  new fetch address, sampled when redirect=1.

Function
REQ-003 The block SHALL be the instruction producer for the decode FSM, delivering words in program order over a valid/ready handshake.
REQ-004 The block SHALL hold a 2-entry FIFO of {pc, inst}; inst_out/inst_pc SHALL come from the head entry and be driven from registers.
REQ-005 The FSM states SHALL be START, RUN and SQUASH.
REQ-006 START SHALL last exactly one cycle after reset release, with no read issued, then go to RUN.
REQ-007 In RUN, mem_rd_en SHALL be 1 iff occupancy + in-flight - pop < 2, where pop = inst_valid & inst_ready; mem_addr SHALL equal fetch_pc.
REQ-008 fetch_pc SHALL increment by 1 on each issued read, modulo 2^16: 16'hFFFF wraps to 16'h0000.
REQ-009 Read data SHALL be written to the FIFO on the edge ending the cycle in which mem_rdata is valid, tagged with the address that was issued.
REQ-010 The first instruction after a read SHALL reach inst_valid=1 two cycles after the cycle in which the read was issued.
REQ-011 With inst_ready held at 1, sustained throughput SHALL be one instruction per cycle.
REQ-012 While inst_valid=1 and inst_ready=0, inst_out and inst_pc SHALL hold stable.
REQ-013 With the FIFO full, no read SHALL be issued, and no word SHALL ever be dropped or duplicated.
REQ-014 A push and a pop on the same edge SHALL leave occupancy unchanged.
REQ-015 On an edge with redirect=1:
- the FIFO SHALL be cleared;
- fetch_pc SHALL load redirect_pc;
- any in-flight read SHALL be marked squashed;
- the state SHALL go to SQUASH if a read is in flight, otherwise to RUN.
REQ-016 mem_rd_en SHALL be 0 in the cycle redirect is asserted.
REQ-017 A handshake completing on the redirect edge SHALL count as a transfer; inst_valid SHALL be 0 in the following cycle.
REQ-018 SQUASH SHALL discard the returning mem_rdata, not write it to the FIFO, and issue a read at redirect_pc in the same cycle, then go to RUN.
REQ-019 The first redirected instruction SHALL reach inst_valid=1 no earlier than 3 cycles after the redirect edge.
REQ-020 A redirect arriving while in SQUASH SHALL restart the squash with the newer redirect_pc; the older target SHALL never appear on inst_out.

Reset
REQ-021 While reset=0 the block SHALL hold: state=START, fetch_pc=RESET_PC, FIFO empty, no read in flight, mem_rd_en=0, mem_addr=RESET_PC, inst_valid=0, inst_out=16'h0000, inst_pc=16'h0000.
REQ-022 Reset asserted mid-operation SHALL take effect immediately and asynchronously, discarding all buffered and in-flight data.
REQ-023 Read data returning after reset release for a read issued before reset SHALL be ignored.

Verification
REQ-024 Reset release, inst_ready=1, memory word(a)=a^16'hA500 -> read at 0x0000 in cycle 1; inst_valid first high in cycle 3 with inst_pc=0x0000, inst_out=0xA500; then one instruction per cycle at pc 1, 2, 3 ...
REQ-025 inst_ready=0 for 5 cycles mid-stream -> occupancy reaches 2 and mem_rd_en drops to 0; inst_out stays stable; on resume, consecutive pcs are delivered with no gap or repeat.
REQ-026 redirect=1, redirect_pc=0x0040 with one read in flight -> the in-flight word never appears; next inst_pc=0x0040, followed by 0x0041.
REQ-027 Redirect on the same edge as a completing handshake -> the handshake counts; inst_valid=0 next cycle; the redirected stream starts at redirect_pc.
REQ-028 RESET_PC=16'hFFFE, streaming -> inst_pc sequence FFFE, FFFF, 0000, 0001.
REQ-029 reset pulsed low for one cycle while the FIFO is full -> all outputs at reset values during the pulse; the stream restarts at RESET_PC; the stale return is not delivered.
